// File: rtl/wrb_arbiter_buffer.sv
// Writeback collection stage in front of the physical register file.
// Each source owns a one-entry slot; a round-robin picker drains up to two
// slots per cycle onto the two regfile write ports. The second pick must
// target a different register than the first, so a same-register result is
// deferred to a later cycle instead of racing the first write.
module wrb_arbiter_buffer #(
    parameter int NUM_SRC        = 7,
    parameter int REG_SIZE_WIDTH = 7,
    parameter int XLEN           = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_i,
    input  logic [NUM_SRC-1:0]                src_valid_i,
    output logic [NUM_SRC-1:0]                src_ready_o,
    input  logic [NUM_SRC*REG_SIZE_WIDTH-1:0] src_addr_i,
    input  logic [NUM_SRC*XLEN-1:0]           src_data_i,
    output logic                              wr_first_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]         wr_first_address_o,
    output logic [XLEN-1:0]                   wr_first_data_o,
    output logic                              wr_second_valid_o,
    output logic [REG_SIZE_WIDTH-1:0]         wr_second_address_o,
    output logic [XLEN-1:0]                   wr_second_data_o,
    output logic [$clog2(NUM_SRC+1)-1:0]      pending_cnt_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(NUM_SRC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    // Cyclic successor of a slot index.
    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    logic [NUM_SRC-1:0]        slot_v_q, slot_v_d;
    logic [REG_SIZE_WIDTH-1:0] slot_addr_q [NUM_SRC];
    logic [REG_SIZE_WIDTH-1:0] slot_addr_d [NUM_SRC];
    logic [XLEN-1:0]           slot_data_q [NUM_SRC];
    logic [XLEN-1:0]           slot_data_d [NUM_SRC];
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;

    logic [REG_SIZE_WIDTH-1:0] src_addr [NUM_SRC];
    logic [XLEN-1:0]           src_data [NUM_SRC];

    logic                      g0_found, g1_found;
    logic [IDX_W-1:0]          g0_idx, g1_idx;
    logic [IDX_W-1:0]          scan_idx;
    logic [NUM_SRC-1:0]        granted;
    logic [NUM_SRC-1:0]        accept;
    logic [CNT_W-1:0]          pending_cnt;

    // Unpack the per-source request fields.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign src_addr[gi] = src_addr_i[gi*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
        assign src_data[gi] = src_data_i[gi*XLEN +: XLEN];
    end

    // Pick two occupied slots from registered state only: first from rr_ptr,
    // second after the first with a different destination register.
    always_comb begin
        g0_found = 1'b0;
        g0_idx   = '0;
        g1_found = 1'b0;
        g1_idx   = '0;
        scan_idx = rr_ptr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!g0_found && slot_v_q[scan_idx]) begin
                g0_found = 1'b1;
                g0_idx   = scan_idx;
            end
            scan_idx = inc_idx(scan_idx);
        end
        scan_idx = inc_idx(g0_idx);
        for (int k = 1; k < NUM_SRC; k++) begin
            if (g0_found && !g1_found && slot_v_q[scan_idx] &&
                (slot_addr_q[scan_idx] != slot_addr_q[g0_idx])) begin
                g1_found = 1'b1;
                g1_idx   = scan_idx;
            end
            scan_idx = inc_idx(scan_idx);
        end
    end

    // One-hot-per-pick mask of slots draining this cycle.
    always_comb begin
        granted = '0;
        if (g0_found) granted[g0_idx] = 1'b1;
        if (g1_found) granted[g1_idx] = 1'b1;
    end

    // A slot can take a new result when empty or draining; flush blocks intake.
    assign src_ready_o = ~{NUM_SRC{flush_i}} & (~slot_v_q | granted);
    assign accept      = src_valid_i & src_ready_o;

    assign wr_first_valid_o    = g0_found;
    assign wr_first_address_o  = g0_found ? slot_addr_q[g0_idx] : '0;
    assign wr_first_data_o     = g0_found ? slot_data_q[g0_idx] : '0;
    assign wr_second_valid_o   = g1_found;
    assign wr_second_address_o = g1_found ? slot_addr_q[g1_idx] : '0;
    assign wr_second_data_o    = g1_found ? slot_data_q[g1_idx] : '0;

    // Occupancy count of the registered slots.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_cnt = pending_cnt + CNT_W'(slot_v_q[i]);
        end
    end
    assign pending_cnt_o = pending_cnt;

    // Next slot contents and pointer: writes to P0 are swallowed, a load
    // overrides a same-cycle drain, flush empties everything.
    always_comb begin
        slot_v_d    = slot_v_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush_i) begin
            slot_v_d = '0;
            rr_ptr_d = '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i] && (src_addr[i] != '0)) begin
                    slot_v_d[i]    = 1'b1;
                    slot_addr_d[i] = src_addr[i];
                    slot_data_d[i] = src_data[i];
                end else if (granted[i]) begin
                    slot_v_d[i] = 1'b0;
                end
            end
            if (g1_found) begin
                rr_ptr_d = inc_idx(g1_idx);
            end else if (g0_found) begin
                rr_ptr_d = inc_idx(g0_idx);
            end
        end
    end

    // Slot and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            slot_v_q    <= slot_v_d;
            rr_ptr_q    <= rr_ptr_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
        end
    end

endmodule

// File: tb/tb_wrb_arbiter_buffer.sv
// Directed bench for wrb_arbiter_buffer. Accepted results that are expected
// to reach the regfile are queued in expected write order; every cycle the
// write ports are popped against that queue.
module tb_wrb_arbiter_buffer;

    localparam int NUM_SRC = 7;
    localparam int AW      = 7;
    localparam int DW      = 64;
    localparam int CW      = $clog2(NUM_SRC + 1);

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC*AW-1:0] src_addr;
    logic [NUM_SRC*DW-1:0] src_data;
    logic                  wr_first_valid;
    logic [AW-1:0]         wr_first_address;
    logic [DW-1:0]         wr_first_data;
    logic                  wr_second_valid;
    logic [AW-1:0]         wr_second_address;
    logic [DW-1:0]         wr_second_data;
    logic [CW-1:0]         pending_cnt;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    wrb_arbiter_buffer #(.NUM_SRC(NUM_SRC), .REG_SIZE_WIDTH(AW), .XLEN(DW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (flush),
        .src_valid_i         (src_valid),
        .src_ready_o         (src_ready),
        .src_addr_i          (src_addr),
        .src_data_i          (src_data),
        .wr_first_valid_o    (wr_first_valid),
        .wr_first_address_o  (wr_first_address),
        .wr_first_data_o     (wr_first_data),
        .wr_second_valid_o   (wr_second_valid),
        .wr_second_address_o (wr_second_address),
        .wr_second_data_o    (wr_second_data),
        .pending_cnt_o       (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i]         = 1'b1;
        src_addr[i*AW +: AW] = a;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic drive_push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(i, a, d);
        push(a, d);
    endtask

    task automatic idle();
        src_valid = '0;
    endtask

    // Compare this cycle's write ports with the scoreboard, then advance one clock.
    task automatic cycle();
        wr_t e;
        if (wr_second_valid) chk("second_implies_first", {127'd0, wr_first_valid}, 128'd1);
        if (wr_first_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $error("FAIL sb_first observed addr=%0h data=%0h expected no write", wr_first_address, wr_first_data);
            end else begin
                e = sb_q.pop_front();
                assert ({wr_first_address, wr_first_data} === {e.addr, e.data}) else begin
                    bad++;
                    $error("FAIL sb_first observed addr=%0h data=%0h expected addr=%0h data=%0h",
                           wr_first_address, wr_first_data, e.addr, e.data);
                end
            end
        end
        if (wr_second_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $error("FAIL sb_second observed addr=%0h data=%0h expected no write", wr_second_address, wr_second_data);
            end else begin
                e = sb_q.pop_front();
                assert ({wr_second_address, wr_second_data} === {e.addr, e.data}) else begin
                    bad++;
                    $error("FAIL sb_second observed addr=%0h data=%0h expected addr=%0h data=%0h",
                           wr_second_address, wr_second_data, e.addr, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [NUM_SRC-1:0] burst_rdy [4];
    logic [CW-1:0]      burst_cnt [4];

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        burst_rdy = '{7'h06, 7'h1E, 7'h7E, 7'h7F};
        burst_cnt = '{CW'(7), CW'(5), CW'(3), CW'(1)};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pending", 128'(pending_cnt), 128'd0);
        chk("rst_first_valid", 128'(wr_first_valid), 128'd0);
        chk("rst_second_valid", 128'(wr_second_valid), 128'd0);
        chk("rst_ready", 128'(src_ready), 128'h7F);
        chk("rst_first_addr_data", {57'd0, wr_first_address, wr_first_data}, 128'd0);
        rst_n = 1'b1;
        cycle();
        $display("txn reset: pending=%0d ready=%0h", pending_cnt, src_ready);

        // Single result: visible one cycle after acceptance
        drive_push(0, 7'd5, 64'hDEAD);
        #1;
        chk("single_ready", 128'(src_ready[0]), 128'd1);
        chk("single_no_early_write", 128'(wr_first_valid), 128'd0);
        cycle();
        idle();
        #1;
        chk("single_first_valid", 128'(wr_first_valid), 128'd1);
        chk("single_second_valid", 128'(wr_second_valid), 128'd0);
        chk("single_pending", 128'(pending_cnt), 128'd1);
        $display("txn single: addr=%0h data=%0h", wr_first_address, wr_first_data);
        cycle();
        chk("single_drained", 128'(pending_cnt), 128'd0);

        // Burst of seven; pointer sits at 1 so drain order is 1..6 then 0
        for (int k = 1; k <= NUM_SRC; k++) begin
            drive_push(k % NUM_SRC, AW'(10 + (k % NUM_SRC)), 64'hB000 + DW'(k % NUM_SRC));
        end
        #1;
        chk("burst_accept_ready", 128'(src_ready), 128'h7F);
        cycle();
        idle();
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("burst_ready", 128'(src_ready), 128'(burst_rdy[c]));
            chk("burst_pending", 128'(pending_cnt), 128'(burst_cnt[c]));
            $display("txn burst c%0d: w0=%0b/%0h w1=%0b/%0h", c, wr_first_valid, wr_first_address,
                     wr_second_valid, wr_second_address);
            cycle();
        end
        chk("burst_empty", 128'(pending_cnt), 128'd0);
        chk("burst_sb_empty", 128'(sb_q.size()), 128'd0);

        // Flush an idle buffer to bring the pointer back to 0
        flush = 1'b1;
        #1;
        chk("flush_ready_low", 128'(src_ready), 128'd0);
        cycle();
        flush = 1'b0;

        // Same destination register: second one deferred
        drive_push(1, 7'd20, 64'hA1);
        drive_push(4, 7'd20, 64'hA4);
        #1;
        cycle();
        idle();
        #1;
        chk("same_addr_second_off", 128'(wr_second_valid), 128'd0);
        chk("same_addr_first_addr", 128'(wr_first_address), 128'd20);
        chk("same_addr_pending2", 128'(pending_cnt), 128'd2);
        $display("txn same_addr c1: addr=%0h data=%0h", wr_first_address, wr_first_data);
        cycle();
        chk("same_addr_c2_valid", 128'(wr_first_valid), 128'd1);
        chk("same_addr_pending1", 128'(pending_cnt), 128'd1);
        $display("txn same_addr c2: addr=%0h data=%0h", wr_first_address, wr_first_data);
        cycle();
        chk("same_addr_sb_empty", 128'(sb_q.size()), 128'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;

        // Round-robin: src0/src1 keep issuing while src2/src3 wait
        drive_push(0, 7'd30, 64'h100);
        drive_push(1, 7'd31, 64'h200);
        drive_push(2, 7'd32, 64'h300);
        drive_push(3, 7'd33, 64'h400);
        #1;
        cycle();
        idle();
        drive_push(0, 7'd30, 64'h101);
        drive_push(1, 7'd31, 64'h201);
        #1;
        chk("rr_r1_ready", 128'(src_ready), 128'h73);
        cycle();
        drive(0, 7'd30, 64'h102);
        drive(1, 7'd31, 64'h202);
        #1;
        chk("rr_r2_ready", 128'(src_ready), 128'h7C);
        chk("rr_r2_first_addr", 128'(wr_first_address), 128'd32);
        chk("rr_r2_second_addr", 128'(wr_second_address), 128'd33);
        $display("txn rr r2: w0=%0h w1=%0h", wr_first_address, wr_second_address);
        cycle();
        push(7'd30, 64'h102);
        push(7'd31, 64'h202);
        #1;
        chk("rr_r3_ready", 128'(src_ready), 128'h7F);
        cycle();
        idle();
        #1;
        cycle();
        chk("rr_pending", 128'(pending_cnt), 128'd0);
        chk("rr_sb_empty", 128'(sb_q.size()), 128'd0);

        // Write to P0 is accepted and discarded
        drive(3, 7'd0, 64'hBAD);
        #1;
        chk("p0_ready", 128'(src_ready[3]), 128'd1);
        cycle();
        idle();
        #1;
        chk("p0_pending", 128'(pending_cnt), 128'd0);
        chk("p0_no_write", 128'(wr_first_valid), 128'd0);
        $display("txn p0: pending=%0d w0=%0b", pending_cnt, wr_first_valid);
        cycle();

        // Flush with four pending; pointer is 2 so slots 2 and 3 still write
        drive(0, 7'd40, 64'hC0);
        drive(1, 7'd41, 64'hC1);
        drive_push(2, 7'd42, 64'hC2);
        drive_push(3, 7'd43, 64'hC3);
        #1;
        cycle();
        idle();
        flush = 1'b1;
        #1;
        chk("flush_pending4", 128'(pending_cnt), 128'd4);
        chk("flush_ready_zero", 128'(src_ready), 128'd0);
        chk("flush_both_write", {126'd0, wr_first_valid, wr_second_valid}, 128'd3);
        $display("txn flush: w0=%0h w1=%0h", wr_first_address, wr_second_address);
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_after_pending", 128'(pending_cnt), 128'd0);
        chk("flush_after_no_write", 128'(wr_first_valid), 128'd0);
        // Pointer back at 0: slot 0 must win over slot 5
        drive_push(0, 7'd60, 64'hD0);
        drive_push(5, 7'd65, 64'hD5);
        #1;
        cycle();
        idle();
        #1;
        chk("flush_rr_zero", 128'(wr_first_address), 128'd60);
        cycle();
        chk("flush_sb_empty", 128'(sb_q.size()), 128'd0);

        // Asynchronous reset with three slots occupied
        drive(1, 7'd50, 64'hE1);
        drive(2, 7'd51, 64'hE2);
        drive(3, 7'd52, 64'hE3);
        #1;
        cycle();
        idle();
        #1;
        chk("mid_rst_pre_pending", 128'(pending_cnt), 128'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", 128'(pending_cnt), 128'd0);
        chk("mid_rst_valids", {126'd0, wr_first_valid, wr_second_valid}, 128'd0);
        chk("mid_rst_ready", 128'(src_ready), 128'h7F);
        $display("txn mid_reset: pending=%0d ready=%0h", pending_cnt, src_ready);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_pending", 128'(pending_cnt), 128'd0);
        chk("final_sb_empty", 128'(sb_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
